rfnoc_reset_sequencer: RTL and testbench

//   Synthesizable reset sequencer for a chain of NUM_STAGES downstream blocks
//   (e.g. clocking -> radio -> DSP -> transport).

---
 rtl/rfnoc_reset_sequencer.sv | 201 ++++++++++++++++++++
 tb/tb_rfnoc_reset_sequencer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/rfnoc_reset_sequencer.sv
// -----------------------------------------------------------------------------
// rfnoc_reset_sequencer
//
// Purpose:
//   Sequences the resets of a chain of NUM_STAGES downstream blocks. All
//   stages are first held in reset for HOLD_CYCLES. The stages are then
//   released one at a time in index order. After each release the sequencer
//   waits for that stage's ack, then idles for GAP_CYCLES before it releases
//   the next stage. If a stage does not ack within ACK_TIMEOUT cycles, the
//   sequence stops in an error state. The sequence runs after rst_n
//   deasserts, and again on each req issued while the sequencer is idle
//   (DONE or ERROR).
//
// Ports:
//   clk        in   1           Clock
//   rst_n      in   1           Asynchronous, active-low reset
//   req        in   1           Restart request (pulse or level; ignored while busy)
//   stage_rst  out  NUM_STAGES  Registered active-high reset, one bit per stage
//   stage_ack  in   NUM_STAGES  Per-stage ready, synchronous to clk
//   busy       out  1           Sequence in progress
//   done       out  1           All stages released and acked
//   err        out  1           Ack timeout (sticky until the next req)
//   err_stage  out  IDX_W       Index of the stage that timed out
// -----------------------------------------------------------------------------
module rfnoc_reset_sequencer #(
    parameter int NUM_STAGES  = 4,
    parameter int HOLD_CYCLES = 16,
    parameter int GAP_CYCLES  = 8,
    parameter int ACK_TIMEOUT = 1024,
    parameter int IDX_W       = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req,
    output logic [NUM_STAGES-1:0] stage_rst,
    input  logic [NUM_STAGES-1:0] stage_ack,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [IDX_W-1:0]      err_stage
);

    localparam int CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int TMR_W   = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;

    typedef enum logic [2:0] {
        S_HOLD,
        S_RELEASE,
        S_WAIT_ACK,
        S_GAP,
        S_DONE,
        S_ERROR
    } state_e;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [TMR_W-1:0]      timer_q, timer_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [NUM_STAGES-1:0] stage_rst_q, stage_rst_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic [IDX_W-1:0]      err_stage_q, err_stage_d;

    logic                  ack_cur;
    logic                  last_stage;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can
        // leave a value unassigned and infer a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        timer_d     = timer_q;
        idx_d       = idx_q;
        stage_rst_d = stage_rst_q;
        busy_d      = busy_q;
        done_d      = done_q;
        err_d       = err_q;
        err_stage_d = err_stage_q;

        // Only the ack of the stage currently being brought up matters.
        ack_cur = 1'b0;
        for (int k = 0; k < NUM_STAGES; k++) begin
            if (idx_q == IDX_W'(k)) ack_cur = stage_ack[k];
        end
        last_stage = (idx_q == IDX_W'(NUM_STAGES - 1));

        case (state_q)
            S_HOLD: begin
                if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
                    state_d = S_RELEASE;
                    cnt_d   = '0;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_RELEASE: begin
                for (int k = 0; k < NUM_STAGES; k++) begin
                    if (idx_q == IDX_W'(k)) stage_rst_d[k] = 1'b0;
                end
                timer_d = '0;
                state_d = S_WAIT_ACK;
            end

            S_WAIT_ACK: begin
                // The ack is tested before the timeout, so an ack that lands
                // on the expiry cycle still counts as success.
                if (ack_cur) begin
                    if (last_stage) begin
                        state_d     = S_DONE;
                        stage_rst_d = '0;
                        busy_d      = 1'b0;
                        done_d      = 1'b1;
                    end else if (GAP_CYCLES == 0) begin
                        idx_d   = idx_q + 1'b1;
                        state_d = S_RELEASE;
                    end else begin
                        cnt_d   = '0;
                        state_d = S_GAP;
                    end
                end else if ((ACK_TIMEOUT != 0) && (timer_q == TMR_W'(ACK_TIMEOUT - 1))) begin
                    state_d     = S_ERROR;
                    busy_d      = 1'b0;
                    err_d       = 1'b1;
                    err_stage_d = idx_q;
                    // The stage that failed to come up goes back into reset, so
                    // the frozen vector reads: stages below err_stage released,
                    // err_stage and above in reset.
                    for (int k = 0; k < NUM_STAGES; k++) begin
                        if (idx_q == IDX_W'(k)) stage_rst_d[k] = 1'b1;
                    end
                end else if (timer_q != '1) begin
                    timer_d = timer_q + 1'b1;
                end
            end

            S_GAP: begin
                if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
                    idx_d   = idx_q + 1'b1;
                    state_d = S_RELEASE;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_DONE, S_ERROR: begin
                // A restart is a full power-on style sequence.
                if (req) begin
                    state_d     = S_HOLD;
                    cnt_d       = '0;
                    timer_d     = '0;
                    idx_d       = '0;
                    stage_rst_d = '1;
                    busy_d      = 1'b1;
                    done_d      = 1'b0;
                    err_d       = 1'b0;
                    err_stage_d = '0;
                end
            end

            default: begin
                state_d = S_HOLD;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_HOLD;
            cnt_q       <= '0;
            timer_q     <= '0;
            idx_q       <= '0;
            stage_rst_q <= '1;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            err_stage_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            timer_q     <= timer_d;
            idx_q       <= idx_d;
            stage_rst_q <= stage_rst_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            err_stage_q <= err_stage_d;
        end
    end

    assign stage_rst = stage_rst_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign err_stage = err_stage_q;

endmodule

// File: tb/tb_rfnoc_reset_sequencer.sv
// -----------------------------------------------------------------------------
// tb_rfnoc_reset_sequencer
//
// Directed bench for rfnoc_reset_sequencer with NUM_STAGES=3, HOLD_CYCLES=4,
// GAP_CYCLES=2, ACK_TIMEOUT=8. Inputs are driven 1 time unit after a rising
// edge and outputs are sampled 1 time unit after the following rising edge.
// -----------------------------------------------------------------------------
module tb_rfnoc_reset_sequencer;

    localparam int NS = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req;
    logic [NS-1:0] stage_rst;
    logic [NS-1:0] stage_ack;
    logic          busy;
    logic          done;
    logic          err;
    logic [1:0]    err_stage;

    int n_cmp  = 0;
    int n_fail = 0;

    rfnoc_reset_sequencer #(
        .NUM_STAGES (3),
        .HOLD_CYCLES(4),
        .GAP_CYCLES (2),
        .ACK_TIMEOUT(8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .stage_rst(stage_rst),
        .stage_ack(stage_ack),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .err_stage(err_stage)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] ack;
        logic       req;
        logic [2:0] rst;
        logic       busy;
        logic       done;
        logic       err;
    } vec_t;

    vec_t vecs[19];

    task automatic check(input string name, input logic [2:0] e_rst, input logic e_busy,
                         input logic e_done, input logic e_err, input logic [1:0] e_es);
        n_cmp++;
        if ({stage_rst, busy, done, err, err_stage} !== {e_rst, e_busy, e_done, e_err, e_es}) begin
            n_fail++;
            $display("FAIL %s: got rst=%b busy=%b done=%b err=%b err_stage=%0d, expected rst=%b busy=%b done=%b err=%b err_stage=%0d",
                     name, stage_rst, busy, done, err, err_stage, e_rst, e_busy, e_done, e_err, e_es);
        end
    endtask

    // Drive inputs for one cycle, then move to 1 unit after the next rising edge.
    task automatic step(input logic [2:0] a, input logic r);
        stage_ack = a;
        req       = r;
        @(posedge clk);
        #1;
    endtask

    // Starting from HOLD with a zero counter, ack every stage on its first
    // WAIT_ACK cycle: releases land 4 edges apart and DONE follows the last ack.
    task automatic full_sequence(input string tag);
        logic [2:0] m;
        logic [2:0] m_next;
        for (int e = 1; e <= 4; e++) begin
            step(3'b000, 1'b0);
            check({tag, "_hold"}, 3'b111, 1'b1, 1'b0, 1'b0, 2'd0);
        end
        step(3'b000, 1'b0);
        check({tag, "_rel0"}, 3'b110, 1'b1, 1'b0, 1'b0, 2'd0);
        for (int s = 0; s < NS; s++) begin
            m      = 3'((1 << (s + 1)) - 1);
            m_next = 3'((1 << (s + 2)) - 1);
            step(m, 1'b0);
            if (s == NS - 1) begin
                check({tag, "_done"}, 3'b000, 1'b0, 1'b1, 1'b0, 2'd0);
            end else begin
                check({tag, "_ack"}, ~m, 1'b1, 1'b0, 1'b0, 2'd0);
                step(m, 1'b0);
                step(m, 1'b0);
                check({tag, "_gap"}, ~m, 1'b1, 1'b0, 1'b0, 2'd0);
                step(m, 1'b0);
                check({tag, "_rel"}, ~m_next, 1'b1, 1'b0, 1'b0, 2'd0);
            end
        end
        step(3'b111, 1'b0);
        check({tag, "_done_hold"}, 3'b000, 1'b0, 1'b1, 1'b0, 2'd0);
    endtask

    initial begin
        // Test 1 (slow acks, 5 edges between releases) and test 4 (req while
        // busy is ignored, req in DONE restarts).
        vecs[0]  = '{3'b000, 1'b0, 3'b111, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{3'b000, 1'b0, 3'b111, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{3'b000, 1'b0, 3'b111, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{3'b000, 1'b0, 3'b111, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{3'b000, 1'b0, 3'b110, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{3'b000, 1'b0, 3'b110, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{3'b001, 1'b0, 3'b110, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{3'b001, 1'b1, 3'b110, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{3'b001, 1'b0, 3'b110, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{3'b001, 1'b0, 3'b100, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{3'b001, 1'b0, 3'b100, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{3'b011, 1'b0, 3'b100, 1'b1, 1'b0, 1'b0};
        vecs[12] = '{3'b011, 1'b1, 3'b100, 1'b1, 1'b0, 1'b0};
        vecs[13] = '{3'b011, 1'b1, 3'b100, 1'b1, 1'b0, 1'b0};
        vecs[14] = '{3'b011, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0};
        vecs[15] = '{3'b011, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0};
        vecs[16] = '{3'b111, 1'b1, 3'b000, 1'b0, 1'b1, 1'b0};
        vecs[17] = '{3'b111, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0};
        vecs[18] = '{3'b000, 1'b1, 3'b111, 1'b1, 1'b0, 1'b0};

        rst_n     = 1'b0;
        req       = 1'b0;
        stage_ack = 3'b000;
        #12;
        check("reset_state", 3'b111, 1'b1, 1'b0, 1'b0, 2'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 19; i++) begin
            step(vecs[i].ack, vecs[i].req);
            check($sformatf("vec%0d", i), vecs[i].rst, vecs[i].busy, vecs[i].done,
                  vecs[i].err, 2'd0);
        end

        // Test 2: stage 1 never acks; ERROR exactly 8 edges after its release.
        for (int e = 1; e <= 4; e++) step(3'b000, 1'b0);
        step(3'b000, 1'b0);
        check("t2_rel0", 3'b110, 1'b1, 1'b0, 1'b0, 2'd0);
        step(3'b001, 1'b0);
        step(3'b001, 1'b0);
        step(3'b001, 1'b0);
        step(3'b001, 1'b0);
        check("t2_rel1", 3'b100, 1'b1, 1'b0, 1'b0, 2'd0);
        for (int k = 1; k <= 7; k++) step(3'b001, 1'b0);
        check("t2_pre_timeout", 3'b100, 1'b1, 1'b0, 1'b0, 2'd0);
        step(3'b001, 1'b0);
        check("t2_timeout", 3'b110, 1'b0, 1'b0, 1'b1, 2'd1);
        step(3'b111, 1'b0);
        step(3'b111, 1'b0);
        check("t2_error_sticky", 3'b110, 1'b0, 1'b0, 1'b1, 2'd1);

        // Test 3: req out of ERROR restarts and a normal sequence completes.
        step(3'b000, 1'b1);
        check("t3_restart", 3'b111, 1'b1, 1'b0, 1'b0, 2'd0);
        full_sequence("t3");

        // Test 5: asynchronous reset in the middle of WAIT_ACK.
        step(3'b000, 1'b1);
        for (int e = 1; e <= 4; e++) step(3'b000, 1'b0);
        step(3'b000, 1'b0);
        step(3'b000, 1'b0);
        check("t5_in_wait", 3'b110, 1'b1, 1'b0, 1'b0, 2'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_async_rst", 3'b111, 1'b1, 1'b0, 1'b0, 2'd0);
        step(3'b000, 1'b0);
        check("t5_rst_held", 3'b111, 1'b1, 1'b0, 1'b0, 2'd0);
        rst_n = 1'b1;
        full_sequence("t5");

        // Test 6: ack on the timeout cycle wins; non-current ack bits ignored.
        step(3'b000, 1'b1);
        for (int e = 1; e <= 4; e++) step(3'b000, 1'b0);
        step(3'b000, 1'b0);
        check("t6_rel0", 3'b110, 1'b1, 1'b0, 1'b0, 2'd0);
        for (int k = 1; k <= 7; k++) step(3'b110, 1'b0);
        check("t6_other_acks_ignored", 3'b110, 1'b1, 1'b0, 1'b0, 2'd0);
        step(3'b111, 1'b0);
        check("t6_ack_at_timeout", 3'b110, 1'b1, 1'b0, 1'b0, 2'd0);
        step(3'b111, 1'b0);
        step(3'b111, 1'b0);
        step(3'b111, 1'b0);
        check("t6_rel1", 3'b100, 1'b1, 1'b0, 1'b0, 2'd0);
        for (int k = 1; k <= 4; k++) step(3'b111, 1'b0);
        check("t6_rel2", 3'b000, 1'b1, 1'b0, 1'b0, 2'd0);
        step(3'b111, 1'b0);
        check("t6_done", 3'b000, 1'b0, 1'b1, 1'b0, 2'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
